// File: rtl/mips_mem_pkg.sv
// Shared constants and state encoding for the Harvard data-port RAM.
package mips_mem_pkg;

  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

  localparam logic [31:0] MEM_BASE_ADDR   = 32'h0000_1000;
  localparam int unsigned MEM_DEPTH_WORDS = 256;
  localparam int unsigned MEM_CNT_W       = 16;

endpackage

// File: rtl/mips_data_ram_sat_counter16.sv
// Saturating event counter: counts enabled cycles and parks at all-ones.
module sat_counter16
  import mips_mem_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 inc_i,
  output logic [MEM_CNT_W-1:0] count_o
);

  logic [MEM_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_data_ram.sv
// Word-organised data RAM for the CPU data port: combinational reads,
// synchronous writes, zeroing sweep after reset, sticky error flags.
module mips_data_ram
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        ready,
  output logic        err_misaligned,
  output logic        err_range,
  output logic        err_collision,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  mem_state_e        state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic              err_mis_q, err_mis_d;
  logic              err_rng_q, err_rng_d;
  logic              err_col_q, err_col_d;

  logic [29:0]       offset_w;
  logic [IDX_W-1:0]  idx;
  logic              aligned, in_range, any_strobe, rd_acc, wr_acc;

  // Range check compares before subtracting so addresses below the base
  // cannot wrap around into the window.
  assign offset_w   = data_address[31:2] - BASE_ADDR[31:2];
  assign idx        = offset_w[IDX_W-1:0];
  assign aligned    = (data_address[1:0] == 2'b00);
  assign in_range   = (data_address >= BASE_ADDR) && (offset_w[29:IDX_W] == '0);
  assign any_strobe = data_read | data_write;
  assign rd_acc     = ready & data_read  & aligned & in_range;
  assign wr_acc     = ready & data_write & aligned & in_range;

  assign ready         = (state_q == MEM_READY);
  assign data_readdata = rd_acc ? mem_q[idx] : 32'h0;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == MEM_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_d = MEM_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MEM_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == MEM_CLEAR) mem_q[clr_idx_q] <= 32'h0;
      else if (wr_acc)          mem_q[idx]       <= data_writedata;
    end
  end

  // Misalignment masks the range flag for the same access.
  always_comb begin
    err_mis_d = err_mis_q;
    err_rng_d = err_rng_q;
    err_col_d = err_col_q;
    if (ready && any_strobe) begin
      if (!aligned)       err_mis_d = 1'b1;
      else if (!in_range) err_rng_d = 1'b1;
      if (data_read && data_write) err_col_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_mis_q <= 1'b0;
      err_rng_q <= 1'b0;
      err_col_q <= 1'b0;
    end else begin
      err_mis_q <= err_mis_d;
      err_rng_q <= err_rng_d;
      err_col_q <= err_col_d;
    end
  end

  assign err_misaligned = err_mis_q;
  assign err_range      = err_rng_q;
  assign err_collision  = err_col_q;

  sat_counter16 u_rd_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (rd_acc),
    .count_o (rd_count)
  );

  sat_counter16 u_wr_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (wr_acc),
    .count_o (wr_count)
  );

endmodule

// File: tb/tb_mips_data_ram.sv
// Randomised self-checking bench for mips_data_ram against an array-based
// reference model of the memory window, error flags and counters.
module tb_mips_data_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_address = 32'h0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = 32'h0;
  logic [31:0] data_readdata;
  logic        ready, err_misaligned, err_range, err_collision;
  logic [15:0] rd_count, wr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [DEPTH];
  bit          m_ready;
  bit          m_mis, m_rng, m_col;
  int          m_rd, m_wr;

  mips_data_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .ready          (ready),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .err_collision  (err_collision),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned la = a;
    return (la >= longint'(BASE)) && (la < longint'(BASE) + DEPTH * 4);
  endfunction

  function automatic bit acc(input logic s, input logic [31:0] a);
    return m_ready && s && (a[1:0] == 2'b00) && in_win(a);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
    return acc(rd, a) ? mm[widx(a)] : 32'h0;
  endfunction

  function automatic void model_update(input logic rd, input logic wr,
                                       input logic [31:0] a, input logic [31:0] wd);
    if (m_ready && (rd || wr)) begin
      if (a[1:0] != 2'b00) m_mis = 1;
      else if (!in_win(a)) m_rng = 1;
      if (rd && wr) m_col = 1;
    end
    if (acc(rd, a) && m_rd < 65535) m_rd++;
    if (acc(wr, a) && m_wr < 65535) m_wr++;
    if (acc(wr, a)) mm[widx(a)] = wd;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] seen);
    data_read = rd; data_write = wr; data_address = a; data_writedata = wd;
    #1 seen = data_readdata;
    @(posedge clk);
    #1 model_update(rd, wr, a, wd);
    @(negedge clk);
    data_read = 1'b0; data_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; data_read = 1'b0; data_write = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 0; m_mis = 0; m_rng = 0; m_col = 0; m_rd = 0; m_wr = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < 1000) begin
      @(posedge clk);
      #1 edges++;
      if (ready === 1'b1) break;
    end
    if (ready === 1'b1) begin
      m_ready = 1;
      for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int edges;
    logic [31:0] seen;
    do_reset();
    checks++;
    if (ready !== 1'b0 || rd_count !== 16'h0 || wr_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b rd=%h wr=%h required ready=0 rd=0 wr=0",
               ready, rd_count, wr_count);
    end
    checks++;
    if ({err_misaligned, err_range, err_collision} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000",
               {err_misaligned, err_range, err_collision});
    end
    // Strobes during the sweep must be ignored entirely.
    data_read = 1'b1; data_write = 1'b1; data_address = BASE + 32'h8;
    data_writedata = 32'hFFFF_FFFF; data_address = 32'h0000_0FFF;
    #1;
    checks++;
    if (data_readdata !== 32'h0) begin
      errors++;
      $display("FAIL clear_readdata: got %h required 00000000", data_readdata);
    end
    data_address = BASE + 32'h8;
    wait_ready(edges);
    data_read = 1'b0; data_write = 1'b0;
    checks++;
    if (edges !== 256) begin
      errors++;
      $display("FAIL sweep_edges: got %0d required 256", edges);
    end
    checks++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0 ||
        {err_misaligned, err_range, err_collision} !== 3'b000) begin
      errors++;
      $display("FAIL clear_ignored: rd=%h wr=%h flags=%b required 0 0 000", rd_count,
               wr_count, {err_misaligned, err_range, err_collision});
    end
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0, seen);
    checks++;
    if (seen !== 32'h0) begin
      errors++;
      $display("FAIL read_first_word: got %h required 00000000", seen);
    end
    drive(1'b1, 1'b0, 32'h0000_13FC, 32'h0, seen);
    checks++;
    if (seen !== 32'h0) begin
      errors++;
      $display("FAIL read_last_word: got %h required 00000000", seen);
    end
    drive(1'b1, 1'b0, BASE + 32'h8, 32'h0, seen);
    checks++;
    if (seen !== 32'h0) begin
      errors++;
      $display("FAIL clear_write_dropped: got %h required 00000000", seen);
    end
  endtask

  task automatic test_write_read();
    int edges;
    logic [31:0] seen;
    do_reset();
    wait_ready(edges);
    drive(1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, seen);
    drive(1'b1, 1'b0, 32'h0000_1004, 32'h0, seen);
    checks++;
    if (seen !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_readback: got %h required deadbeef", seen);
    end
    checks++;
    if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
      errors++;
      $display("FAIL wr_rd_counts: wr=%0d rd=%0d required 1 1", wr_count, rd_count);
    end
  endtask

  task automatic test_errors();
    int edges;
    logic [31:0] seen, exp;
    do_reset();
    wait_ready(edges);
    drive(1'b0, 1'b1, 32'h0000_1006, 32'hA5A5_A5A5, seen);
    checks++;
    if (err_misaligned !== 1'b1 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_only: mis=%b rng=%b required 1 0", err_misaligned, err_range);
    end
    drive(1'b0, 1'b1, 32'h0000_1400, 32'h5A5A_5A5A, seen);
    exp = model_read(1'b1, 32'h0000_0FFC);
    drive(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, seen);
    checks++;
    if (seen !== exp) begin
      errors++;
      $display("FAIL below_base_read: got %h required %h", seen, exp);
    end
    checks++;
    if (err_misaligned !== 1'b1 || err_range !== 1'b1 || err_collision !== 1'b0) begin
      errors++;
      $display("FAIL error_flags: mis=%b rng=%b col=%b required 1 1 0",
               err_misaligned, err_range, err_collision);
    end
    checks++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
      errors++;
      $display("FAIL rejected_counts: rd=%0d wr=%0d required 0 0", rd_count, wr_count);
    end
    for (int a = 0; a < 3; a++) begin
      logic [31:0] ad;
      ad = BASE + 32'(a * 4) + ((a == 2) ? 32'h3F8 : 32'h0);
      exp = model_read(1'b1, ad);
      drive(1'b1, 1'b0, ad, 32'h0, seen);
      checks++;
      if (seen !== exp) begin
        errors++;
        $display("FAIL mem_unchanged: addr=%h got %h required %h", ad, seen, exp);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] seen;
    drive(1'b0, 1'b1, 32'h0000_1004, 32'h1111_1111, seen);
    drive(1'b1, 1'b1, 32'h0000_1004, 32'h2222_2222, seen);
    checks++;
    if (seen !== 32'h1111_1111) begin
      errors++;
      $display("FAIL collision_old_data: got %h required 11111111", seen);
    end
    checks++;
    if (err_collision !== 1'b1) begin
      errors++;
      $display("FAIL collision_flag: got %b required 1", err_collision);
    end
    checks++;
    if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr)) begin
      errors++;
      $display("FAIL collision_counts: rd=%0d wr=%0d required %0d %0d",
               rd_count, wr_count, m_rd, m_wr);
    end
    drive(1'b1, 1'b0, 32'h0000_1004, 32'h0, seen);
    checks++;
    if (seen !== 32'h2222_2222) begin
      errors++;
      $display("FAIL collision_new_data: got %h required 22222222", seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] seen, exp, a;
    logic rd, wr;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(9))
        0:       a = BASE + 32'($urandom_range(DEPTH * 4 - 1));
        1:       a = BASE - 32'(4 * $urandom_range(1, 8));
        2:       a = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 8));
        3:       a = 32'hFFFF_F000 + 32'(4 * $urandom_range(0, 8));
        default: a = BASE + 32'(4 * $urandom_range(DEPTH - 1));
      endcase
      rd = 1'($urandom_range(1));
      wr = 1'($urandom_range(1));
      exp = model_read(rd, a);
      drive(rd, wr, a, $urandom, seen);
      checks++;
      if (seen !== exp) begin
        errors++;
        $display("FAIL random_read: n=%0d addr=%h rd=%b wr=%b got %h required %h",
                 n, a, rd, wr, seen, exp);
      end
    end
    checks++;
    if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr)) begin
      errors++;
      $display("FAIL random_counts: rd=%0d wr=%0d required %0d %0d",
               rd_count, wr_count, m_rd, m_wr);
    end
    checks++;
    if ({err_misaligned, err_range, err_collision} !== {m_mis, m_rng, m_col}) begin
      errors++;
      $display("FAIL random_flags: got %b required %b",
               {err_misaligned, err_range, err_collision}, {m_mis, m_rng, m_col});
    end
  endtask

  task automatic test_reset_mid_sweep();
    int edges;
    do_reset();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: got %b required 0", ready);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_ready: got %b required 0", ready);
    end
    do_reset();
    wait_ready(edges);
    checks++;
    if (edges !== 256) begin
      errors++;
      $display("FAIL restart_edges: got %0d required 256", edges);
    end
  endtask

  task automatic test_saturation();
    int edges;
    logic [31:0] seen;
    do_reset();
    wait_ready(edges);
    for (int i = 0; i < 65540; i++)
      drive(1'b1, 1'b0, BASE + 32'(4 * (i % DEPTH)), 32'h0, seen);
    checks++;
    if (rd_count !== 16'hFFFF || 16'(m_rd) !== 16'hFFFF) begin
      errors++;
      $display("FAIL rd_saturate: got %h required ffff", rd_count);
    end
    checks++;
    if (wr_count !== 16'h0) begin
      errors++;
      $display("FAIL wr_idle: got %h required 0000", wr_count);
    end
    do_reset();
    checks++;
    if (rd_count !== 16'h0) begin
      errors++;
      $display("FAIL rd_after_reset: got %h required 0000", rd_count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_errors();
    test_collision();
    test_random();
    test_reset_mid_sweep();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
